video_mnist_wb_frame_sequencer: RTL and testbench

- Frame-synchronous register-update controller for the MNIST CNN video path (video_mnist_cnn / video_mnist_color parameter ports).
- CPU queues (address, select, data) write entries through a Wishbone slave port.
- After a commit, the block waits for the next AXI4-Stream frame start, then drains the queue as Wishbone writes on its master port.
- Parameter changes (threshold, invert, mode) therefore never land mid-frame.

---
 rtl/video_mnist_wb_frame_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_video_mnist_wb_frame_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mnist_wb_frame_sequencer.sv
// rtl/video_mnist_wb_frame_sequencer.sv - frame-synchronous Wishbone register-update queue
// Optional ack watchdog: define VIDEO_MNIST_WB_FRAME_SEQUENCER_TIMEOUT_EN.
module video_mnist_wb_frame_sequencer #(
  parameter int WB_ADR_WIDTH    = 8,
  parameter int WB_DAT_WIDTH    = 32,
  parameter int WB_SEL_WIDTH    = WB_DAT_WIDTH / 8,
  parameter int M_WB_ADR_WIDTH  = 8,
  parameter int QUEUE_PTR_WIDTH = 4,
  parameter int TUSER_WIDTH     = 1,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [TUSER_WIDTH-1:0]    mon_axi4s_tuser,
  input  logic                      mon_axi4s_tvalid,
  input  logic                      mon_axi4s_tready,
  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic                      s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]   s_wb_sel_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,
  output logic [M_WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0]   m_wb_dat_o,
  output logic                      m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0]   m_wb_sel_o,
  output logic                      m_wb_stb_o,
  input  logic                      m_wb_ack_i,
  output logic                      busy
);

  localparam int DEPTH = 1 << QUEUE_PTR_WIDTH;
  localparam int CW    = QUEUE_PTR_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL    = WB_ADR_WIDTH'(0);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS = WB_ADR_WIDTH'(1);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_EADR   = WB_ADR_WIDTH'(2);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_ESEL   = WB_ADR_WIDTH'(3);
  localparam logic [WB_ADR_WIDTH-1:0] ADR_EDAT   = WB_ADR_WIDTH'(4);

  localparam logic [QUEUE_PTR_WIDTH-1:0] PTR_ONE    = QUEUE_PTR_WIDTH'(1);
  localparam logic [CW-1:0]              CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]              CNT_FULL   = CW'(DEPTH);

  logic [1:0]                 state_q, state_d;
  logic [QUEUE_PTR_WIDTH-1:0] rd_q, rd_d, wr_q, wr_d, rd_next, head_ptr;
  logic [CW-1:0]              count_q, count_d;
  logic                       sync_q, sync_d;
  logic                       ovf_q, ovf_d;
  logic                       tmo_q, tmo_d;
  logic                       abort_pend_q, abort_pend_d;
  logic [M_WB_ADR_WIDTH-1:0]  eadr_q, eadr_d;
  logic [WB_SEL_WIDTH-1:0]    esel_q, esel_d;
  logic [M_WB_ADR_WIDTH-1:0]  m_adr_q, m_adr_d;
  logic [WB_SEL_WIDTH-1:0]    m_sel_q, m_sel_d;
  logic [WB_DAT_WIDTH-1:0]    m_dat_q, m_dat_d;
  logic                       flush, load_head;

  logic [M_WB_ADR_WIDTH-1:0]  q_adr_mem [DEPTH];
  logic [WB_SEL_WIDTH-1:0]    q_sel_mem [DEPTH];
  logic [WB_DAT_WIDTH-1:0]    q_dat_mem [DEPTH];

  logic wr_en, ctl_wr, commit_req, clr_req, abort_req;
  logic eadr_wr, esel_wr, push_req, push_ok, frame_start;

  assign wr_en       = s_wb_stb_i & s_wb_we_i;
  assign ctl_wr      = wr_en && (s_wb_adr_i == ADR_CTL);
  assign commit_req  = ctl_wr & s_wb_dat_i[1];
  assign clr_req     = ctl_wr & s_wb_dat_i[2];
  assign abort_req   = ctl_wr & s_wb_dat_i[3];
  assign eadr_wr     = wr_en && (s_wb_adr_i == ADR_EADR);
  assign esel_wr     = wr_en && (s_wb_adr_i == ADR_ESEL);
  assign push_req    = wr_en && (s_wb_adr_i == ADR_EDAT);
  assign push_ok     = push_req && (state_q == ST_IDLE) && (count_q != CNT_FULL);
  assign frame_start = mon_axi4s_tuser[0] & mon_axi4s_tvalid & mon_axi4s_tready;
  assign rd_next     = rd_q + PTR_ONE;

`ifdef VIDEO_MNIST_WB_FRAME_SEQUENCER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Restarts on every ack so each transfer gets a full window.
  assign tmo_cnt_d = (state_q == ST_ISSUE && !m_wb_ack_i) ? tmo_cnt_q + TMO_W'(1) : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    count_d      = count_q;
    sync_d       = sync_q;
    ovf_d        = ovf_q;
    tmo_d        = tmo_q;
    abort_pend_d = abort_pend_q;
    eadr_d       = eadr_q;
    esel_d       = esel_q;
    m_adr_d      = m_adr_q;
    m_sel_d      = m_sel_q;
    m_dat_d      = m_dat_q;
    flush        = 1'b0;
    load_head    = 1'b0;
    head_ptr     = rd_q;

    if (ctl_wr)  sync_d = s_wb_dat_i[0];
    if (clr_req) begin
      ovf_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (eadr_wr) eadr_d = s_wb_dat_i[M_WB_ADR_WIDTH-1:0];
    if (esel_wr) esel_d = s_wb_dat_i[WB_SEL_WIDTH-1:0];
    if (push_req) begin
      if (push_ok) begin
        wr_d    = wr_q + PTR_ONE;
        count_d = count_q + CNT_ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (abort_req)                           flush   = 1'b1;
        else if (commit_req && count_q != '0)    state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // sync_d so a SYNC write in this very cycle already applies.
        if (abort_req) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (!sync_d || frame_start) begin
          state_d   = ST_ISSUE;
          load_head = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (abort_req) abort_pend_d = 1'b1;
        if (m_wb_ack_i) begin
          rd_d    = rd_next;
          count_d = count_q - CNT_ONE;
          if (abort_req || abort_pend_q) begin
            flush        = 1'b1;
            state_d      = ST_IDLE;
            abort_pend_d = 1'b0;
          end else if (count_q == CNT_ONE) begin
            state_d = ST_IDLE;
          end else begin
            load_head = 1'b1;
            head_ptr  = rd_next;
          end
        end
`ifdef VIDEO_MNIST_WB_FRAME_SEQUENCER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          tmo_d        = 1'b1;
          flush        = 1'b1;
          state_d      = ST_IDLE;
          abort_pend_d = 1'b0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end
    // Master bus fields only change when a new head is presented, so they hold while stb is low.
    if (load_head) begin
      m_adr_d = q_adr_mem[head_ptr];
      m_sel_d = q_sel_mem[head_ptr];
      m_dat_d = q_dat_mem[head_ptr];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      sync_q       <= 1'b0;
      ovf_q        <= 1'b0;
      tmo_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      eadr_q       <= '0;
      esel_q       <= '0;
      m_adr_q      <= '0;
      m_sel_q      <= '0;
      m_dat_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      sync_q       <= sync_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      abort_pend_q <= abort_pend_d;
      eadr_q       <= eadr_d;
      esel_q       <= esel_d;
      m_adr_q      <= m_adr_d;
      m_sel_q      <= m_sel_d;
      m_dat_q      <= m_dat_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) begin
      q_adr_mem[wr_q] <= eadr_q;
      q_sel_mem[wr_q] <= esel_q;
      q_dat_mem[wr_q] <= s_wb_dat_i;
    end
  end

  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      ADR_CTL:    s_wb_dat_o[0] = sync_q;
      ADR_STATUS: begin
        s_wb_dat_o[0]                   = (state_q != ST_IDLE);
        s_wb_dat_o[1]                   = (state_q == ST_ARMED);
        s_wb_dat_o[2]                   = ovf_q;
        s_wb_dat_o[3]                   = tmo_q;
        s_wb_dat_o[QUEUE_PTR_WIDTH+8:8] = count_q;
      end
      ADR_EADR:   s_wb_dat_o[M_WB_ADR_WIDTH-1:0] = eadr_q;
      ADR_ESEL:   s_wb_dat_o[WB_SEL_WIDTH-1:0]   = esel_q;
      default:    s_wb_dat_o = '0;
    endcase
  end

  assign s_wb_ack_o = s_wb_stb_i;
  assign m_wb_stb_o = (state_q == ST_ISSUE);
  assign m_wb_we_o  = m_wb_stb_o;
  assign m_wb_adr_o = m_adr_q;
  assign m_wb_sel_o = m_sel_q;
  assign m_wb_dat_o = m_dat_q;
  assign busy       = (state_q != ST_IDLE);

  logic unused_ok;
  assign unused_ok = &{1'b0, s_wb_sel_i, mon_axi4s_tuser, (TIMEOUT_CYCLES > 0)};

endmodule

// File: tb/tb_video_mnist_wb_frame_sequencer.sv
// tb/tb_video_mnist_wb_frame_sequencer.sv - scoreboard bench for the frame-synchronous update queue
module tb_video_mnist_wb_frame_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [0:0]  mon_axi4s_tuser = '0;
  logic        mon_axi4s_tvalid = 1'b0;
  logic        mon_axi4s_tready = 1'b0;
  logic [7:0]  s_wb_adr_i = '0;
  logic [31:0] s_wb_dat_i = '0;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_we_i = 1'b0;
  logic [3:0]  s_wb_sel_i = 4'hF;
  logic        s_wb_stb_i = 1'b0;
  logic        s_wb_ack_o;
  logic [7:0]  m_wb_adr_o;
  logic [31:0] m_wb_dat_o;
  logic        m_wb_we_o;
  logic [3:0]  m_wb_sel_o;
  logic        m_wb_stb_o;
  logic        m_wb_ack_i = 1'b0;
  logic        busy;

  always #5 aclk = ~aclk;

  video_mnist_wb_frame_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .mon_axi4s_tuser(mon_axi4s_tuser), .mon_axi4s_tvalid(mon_axi4s_tvalid),
    .mon_axi4s_tready(mon_axi4s_tready),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_we_i(s_wb_we_i), .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_ack_o(s_wb_ack_o),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_we_o(m_wb_we_o),
    .m_wb_sel_o(m_wb_sel_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_ack_i(m_wb_ack_i),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] sb[$];
  int ack_delay = 0;
  int wait_cnt = 0;
  int stb_cycles = 0;
  int writes = 0;
  int first_stb_cyc = -1;
  int last_ack_cyc = -1;
  int last_wr_cyc = 0;
  int idle_cyc = 0;
  logic [31:0] st;

  // Master-side responder: compares the presented entry every strobe cycle, acks after ack_delay.
  always @(negedge aclk) begin
    logic [63:0] exp;
    if (m_wb_stb_o) begin
      stb_cycles++;
      if (first_stb_cyc < 0) first_stb_cyc = cyc;
      exp = (sb.size() > 0) ? sb[0] : '1;
      check_eq("m_entry", {20'b0, m_wb_adr_o, m_wb_sel_o, m_wb_dat_o}, exp);
      check_eq("m_we", m_wb_we_o, 1);
      if (wait_cnt >= ack_delay) begin
        m_wb_ack_i = 1'b1;
        wait_cnt = 0;
        writes++;
        last_ack_cyc = cyc;
        if (sb.size() > 0) void'(sb.pop_front());
      end else begin
        m_wb_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      m_wb_ack_i = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic clear_stats();
    stb_cycles = 0;
    writes = 0;
    first_stb_cyc = -1;
    last_ack_cyc = -1;
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat);
    @(negedge aclk);
    s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
    last_wr_cyc = cyc;
    @(posedge aclk);
    #1;
    s_wb_we_i = 1'b0; s_wb_stb_i = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
    @(negedge aclk);
    s_wb_adr_i = adr; s_wb_we_i = 1'b0; s_wb_stb_i = 1'b1;
    #1;
    dat = s_wb_dat_o;
    @(posedge aclk);
    #1;
    s_wb_stb_i = 1'b0;
  endtask

  task automatic push_entry(input logic [7:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input bit accepted);
    wb_write(8'd2, {24'b0, adr});
    wb_write(8'd3, {28'b0, sel});
    wb_write(8'd4, dat);
    if (accepted) sb.push_back({20'b0, adr, sel, dat});
  endtask

  task automatic wait_idle(input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      @(negedge aclk);
      if (!busy) break;
    end
    idle_cyc = cyc;
    check_eq(tag, busy, 0);
  endtask

  task automatic wait_stb(input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      @(negedge aclk);
      if (m_wb_stb_o) break;
    end
    check_eq(tag, m_wb_stb_o, 1);
  endtask

  initial begin
    int fs_cyc;
    repeat (3) @(negedge aclk);
    #1;
    check_eq("rst_stb", m_wb_stb_o, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_madr", m_wb_adr_o, 0);
    check_eq("rst_mdat", m_wb_dat_o, 0);
    s_wb_adr_i = 8'd1;
    #1;
    check_eq("rst_status", s_wb_dat_o, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Frame-synchronous drain of three entries.
    push_entry(8'h10, 4'hF, 32'h7F, 1'b1);
    push_entry(8'h11, 4'hF, 32'h01, 1'b1);
    push_entry(8'h12, 4'hF, 32'h02, 1'b1);
    clear_stats();
    ack_delay = 0;
    wb_write(8'd0, 32'h3);
    mon_axi4s_tvalid = 1'b1; mon_axi4s_tready = 1'b1; mon_axi4s_tuser = 1'b0;
    repeat (100) @(negedge aclk);
    mon_axi4s_tuser = 1'b1; mon_axi4s_tready = 1'b0;
    @(negedge aclk);
    mon_axi4s_tuser = 1'b0; mon_axi4s_tready = 1'b1;
    check_eq("sync_hold_nostb", stb_cycles, 0);
    wb_read(8'd1, st);
    check_eq("sync_armed_busy", st[1:0], 2'b11);
    check_eq("sync_count", st[12:8], 3);
    @(negedge aclk);
    mon_axi4s_tuser = 1'b1;
    fs_cyc = cyc;
    @(posedge aclk);
    #1;
    mon_axi4s_tuser = 1'b0; mon_axi4s_tvalid = 1'b0;
    @(negedge aclk);
    check_eq("sync_stb_rise", m_wb_stb_o, 1);
    wait_idle(50, "sync_idle");
    check_eq("sync_rise_lat", first_stb_cyc - fs_cyc, 1);
    check_eq("sync_writes", writes, 3);
    check_eq("sync_b2b", stb_cycles, 3);
    check_eq("sync_busy_fall", idle_cyc - last_ack_cyc, 1);
    check_eq("sync_sb_empty", sb.size(), 0);

    // Immediate mode with a slow slave.
    push_entry(8'h20, 4'h3, 32'hA5A5_0001, 1'b1);
    clear_stats();
    ack_delay = 5;
    wb_write(8'd0, 32'h2);
    wait_idle(50, "imm_idle");
    check_eq("imm_latency", first_stb_cyc - last_wr_cyc, 2);
    check_eq("imm_stb_cycles", stb_cycles, 6);
    check_eq("imm_writes", writes, 1);

    // Overflow, clear, push while armed, abort while armed.
    for (int i = 0; i < 17; i++) push_entry(8'(i), 4'h1, 32'(i), 1'b0);
    wb_read(8'd1, st);
    check_eq("ovf_count", st[12:8], 16);
    check_eq("ovf_flag", st[2], 1);
    wb_write(8'd0, 32'h4);
    wb_read(8'd1, st);
    check_eq("ovf_clr", st[2], 0);
    check_eq("ovf_clr_count", st[12:8], 16);
    wb_write(8'd0, 32'h3);
    push_entry(8'h55, 4'h1, 32'h55, 1'b0);
    wb_read(8'd1, st);
    check_eq("armed_push_ovf", st[2], 1);
    check_eq("armed_state", st[1:0], 2'b11);
    check_eq("armed_count", st[12:8], 16);
    wb_write(8'd0, 32'h8);
    wb_read(8'd1, st);
    check_eq("abort_armed_status", st[12:0], 13'h004);

    // Abort during ISSUE: current write finishes, rest is flushed.
    wb_write(8'd0, 32'h4);
    for (int i = 0; i < 4; i++) push_entry(8'h30 + 8'(i), 4'hC, 32'hBEEF_0000 + 32'(i), 1'b1);
    clear_stats();
    ack_delay = 3;
    wb_write(8'd0, 32'h2);
    wait_stb(20, "abort_stb_seen");
    wb_write(8'd0, 32'h8);
    wait_idle(50, "abort_idle");
    repeat (10) @(negedge aclk);
    check_eq("abort_writes", writes, 1);
    check_eq("abort_stb_cycles", stb_cycles, 4);
    check_eq("abort_left", sb.size(), 3);
    sb.delete();
    wb_read(8'd1, st);
    check_eq("abort_status", st[12:0], 13'h000);

`ifdef VIDEO_MNIST_WB_FRAME_SEQUENCER_TIMEOUT_EN
    push_entry(8'h40, 4'hF, 32'h1234, 1'b1);
    clear_stats();
    ack_delay = 1000000;
    wb_write(8'd0, 32'h2);
    wait_idle(50, "tmo_idle");
    check_eq("tmo_stb_cycles", stb_cycles, 8);
    wb_read(8'd1, st);
    check_eq("tmo_flag", st[3], 1);
    check_eq("tmo_count", st[12:8], 0);
    sb.delete();
    wb_write(8'd0, 32'h4);
    wb_read(8'd1, st);
    check_eq("tmo_clr", st[3], 0);
`endif

    // Asynchronous reset in the middle of an ISSUE.
    push_entry(8'h50, 4'hF, 32'h9, 1'b1);
    push_entry(8'h51, 4'hF, 32'hA, 1'b1);
    ack_delay = 1000000;
    wb_write(8'd0, 32'h2);
    wait_stb(20, "rst_mid_stb_seen");
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("rst_mid_stb", m_wb_stb_o, 0);
    check_eq("rst_mid_busy", busy, 0);
    s_wb_adr_i = 8'd1;
    #1;
    check_eq("rst_mid_count", s_wb_dat_o[12:8], 0);
    @(negedge aclk);
    aresetn = 1'b1;
    sb.delete();
    ack_delay = 0;
    repeat (3) @(negedge aclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

endmodule
